// File: rtl/uart_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_receiver
// Description : UART byte receiver with a 2-flop input synchronizer, mid-bit
//               sampling, optional even parity and break detection.
//               Optional feature macro: UART_RX_PARITY_EN (8E1 when defined,
//               8N1 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_parity = 3'd3;
`endif
  localparam logic [2:0] c_stop   = 3'd4;
  localparam logic [2:0] c_break  = 3'd5;

  localparam logic [15:0] c_full_pt = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_half_pt = 16'((CLKS_PER_BIT >> 1) - 1);

  logic        r_rx_meta;
  logic        r_rx_s;
  logic [1:0]  r_fill;
  logic        r_armed;
  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        w_sample;
  logic        w_par_ok;
  logic        w_accept;
  logic        w_frame_fail;

  // Two-flop synchronizer; r_fill marks when r_rx_s reflects the real line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_fill    <= 2'b00;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
      r_fill    <= {r_fill[0], 1'b1};
    end
  end

  // Start detection is armed only once a genuine idle-high line has been seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (r_fill[1] && r_rx_s) begin
      r_armed <= 1'b1;
    end
  end

  // Sample point: half a bit into START, a full bit in every other state
  always_comb begin
    w_sample = (r_state == c_start) ? (r_cnt == c_half_pt) : (r_cnt == c_full_pt);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (r_armed && !r_rx_s) w_state_next = c_start;
      c_start: if (w_sample) w_state_next = r_rx_s ? c_idle : c_data;
`ifdef UART_RX_PARITY_EN
      c_data:   if (w_sample && (r_bit_idx == 3'd7)) w_state_next = c_parity;
      c_parity: if (w_sample) w_state_next = c_stop;
`else
      c_data:   if (w_sample && (r_bit_idx == 3'd7)) w_state_next = c_stop;
`endif
      c_stop:  if (w_sample) w_state_next = r_rx_s ? c_idle : c_break;
      c_break: if (r_rx_s) w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // FSM outputs: busy level and end-of-frame decisions at the stop sample
  always_comb begin
    busy         = (r_state != c_idle);
    w_accept     = (r_state == c_stop) && w_sample && r_rx_s && w_par_ok;
    w_frame_fail = (r_state == c_stop) && w_sample && !r_rx_s;
  end

  // Tick counter restarts on each state entry and after each sample point
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if ((w_state_next != r_state) || w_sample ||
                 (r_state == c_idle) || (r_state == c_break)) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Data bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
    end else if (r_state == c_data) begin
      if (w_sample) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end else begin
      r_bit_idx <= 3'd0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_ok;
  logic w_par_fail;

  // Even parity: the parity bit must equal the XOR of the data bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_ok <= 1'b0;
    end else if ((r_state == c_parity) && w_sample) begin
      r_par_ok <= (r_rx_s == ^r_shift);
    end
  end

  // Parity failure only counts when the stop bit itself is good
  always_comb begin
    w_par_ok   = r_par_ok;
    w_par_fail = (r_state == c_stop) && w_sample && r_rx_s && !r_par_ok;
  end

  // Parity error pulse, one cycle after the stop sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= w_par_fail;
    end
  end
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Result register and accept / framing pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= w_accept;
      frame_err  <= w_frame_fail;
      if (w_accept) begin
        data <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_byte_receiver
// Description : Directed self-checking bench for uart_byte_receiver
//               (CLKS_PER_BIT = 16). Follows UART_RX_PARITY_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_receiver;

  localparam int c_cpb = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_checks;
  int n_fail;
  int n_valid, n_perr, n_ferr, n_multi;
  int s_valid, s_perr, s_ferr;
  logic [7:0] q_data[$];

  uart_byte_receiver #(.CLKS_PER_BIT(c_cpb)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        n_valid++;
        q_data.push_back(data);
      end
      if (parity_err) n_perr++;
      if (frame_err) n_ferr++;
      if ((32'(data_valid) + 32'(parity_err) + 32'(frame_err)) > 1) n_multi++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    wait_cycles(c_cpb);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bz) $display("note: parity bit ignored in 8N1 build");
`endif
    send_bit(stop);
  endtask

  // Compare pulse counts since the previous call
  task automatic expect_pulses(input string tag, input int dv, input int pe, input int fe);
    check_eq({tag, "_valid"}, 32'(n_valid - s_valid), 32'(dv));
    check_eq({tag, "_perr"},  32'(n_perr - s_perr),   32'(pe));
    check_eq({tag, "_ferr"},  32'(n_ferr - s_ferr),   32'(fe));
    s_valid = n_valid;
    s_perr  = n_perr;
    s_ferr  = n_ferr;
  endtask

  initial begin
    logic [7:0] v;
    n_checks = 0; n_fail = 0;
    n_valid = 0; n_perr = 0; n_ferr = 0; n_multi = 0;
    s_valid = 0; s_perr = 0; s_ferr = 0;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    wait_cycles(4);

    // Reset state
    check_eq("rst_data",  32'(data), 32'h00);
    check_eq("rst_valid", 32'(data_valid), 0);
    check_eq("rst_perr",  32'(parity_err), 0);
    check_eq("rst_ferr",  32'(frame_err), 0);
    check_eq("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    wait_cycles(20);

    // Good frame 0xA5 (even parity 0)
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cycles(8);
    expect_pulses("a5", 1, 0, 0);
    check_eq("a5_data", 32'(data), 32'hA5);
    check_eq("a5_idle", 32'(busy), 0);

    // 0x01 with wrong parity bit 0
    send_frame(8'h01, 1'b0, 1'b1);
    wait_cycles(8);
`ifdef UART_RX_PARITY_EN
    expect_pulses("par", 0, 1, 0);
    check_eq("par_data", 32'(data), 32'hA5);
`else
    expect_pulses("par", 1, 0, 0);
    check_eq("par_data", 32'(data), 32'h01);
`endif
    v = data;

    // 5-cycle glitch: START samples high at its midpoint and gives up
    uart_rx = 1'b0;
    wait_cycles(5);
    uart_rx = 1'b1;
    wait_cycles(1);
    check_eq("glitch_busy_hi", 32'(busy), 1);
    wait_cycles(8);
    check_eq("glitch_busy_lo", 32'(busy), 0);
    wait_cycles(10);
    expect_pulses("glitch", 0, 0, 0);

    // 0x3C with low stop bit, line stays low -> BREAK
    send_frame(8'h3C, 1'b0, 1'b0);
    uart_rx = 1'b0;
    wait_cycles(40);
    expect_pulses("brk", 0, 0, 1);
    check_eq("brk_busy", 32'(busy), 1);
    check_eq("brk_data", 32'(data), 32'(v));
    uart_rx = 1'b1;
    wait_cycles(6);
    check_eq("brk_exit", 32'(busy), 0);
    wait_cycles(10);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_cycles(8);
    expect_pulses("f55", 1, 0, 0);
    check_eq("f55_data", 32'(data), 32'h55);

    // Back-to-back 0x12, 0x34 with no idle gap
    q_data.delete();
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    wait_cycles(8);
    expect_pulses("b2b", 2, 0, 0);
    check_eq("b2b_n", 32'(q_data.size()), 2);
    if (q_data.size() == 2) begin
      check_eq("b2b_first",  32'(q_data[0]), 32'h12);
      check_eq("b2b_second", 32'(q_data[1]), 32'h34);
    end

    // Reset during bit 4 of 0x0F; the rest of that frame must be ignored
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_rx = 1'b0;
    wait_cycles(6);
    rst_n = 1'b0;
    wait_cycles(3);
    check_eq("abort_rst_busy", 32'(busy), 0);
    check_eq("abort_rst_data", 32'(data), 32'h00);
    rst_n = 1'b1;
    wait_cycles(7);
    for (int i = 5; i < 8; i++) send_bit(1'b0);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    check_eq("abort_no_start", 32'(busy), 0);
    send_bit(1'b1);
    wait_cycles(16);
    expect_pulses("abort", 0, 0, 0);
    send_frame(8'h7E, 1'b0, 1'b1);
    wait_cycles(8);
    expect_pulses("f7e", 1, 0, 0);
    check_eq("f7e_data", 32'(data), 32'h7E);

    check_eq("exclusive", 32'(n_multi), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per UART bit (legal 4..65535).
REQ-002 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-004 SHALL have port uart_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-005 SHALL have port data, output, 8, meaning last accepted byte, held until the next accept.
REQ-006 SHALL have port data_valid, output, 1, meaning one-cycle pulse when data is updated.
REQ-007 SHALL have port parity_err, output, 1, meaning one-cycle pulse when a frame is dropped for bad parity.
REQ-008 SHALL have port frame_err, output, 1, meaning one-cycle pulse when a frame is dropped for a low stop bit.
REQ-009 SHALL have port busy, output, 1, meaning high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 SHALL use a 16-bit tick counter, cleared on every state entry; a sample point is counter == CLKS_PER_BIT-1, except in START, where it is counter == (CLKS_PER_BIT>>1)-1.
REQ-013 SHALL go IDLE->START on the first cycle rx_s==0.
REQ-014 SHALL, at the START sample point, go to DATA if rx_s==0; otherwise treat the pulse as a glitch and return to IDLE with no error pulse.
REQ-015 SHALL, in DATA, sample 8 bits LSB first at successive sample points, then go to PARITY.
REQ-016 SHALL, in PARITY, sample one bit; the check passes when the parity bit equals the XOR of the 8 data bits (even parity); then go to STOP.
REQ-017 SHALL, at the STOP sample point with rx_s==1 and parity passed, load data and pulse data_valid on the next cycle, then return to IDLE.
REQ-018 SHALL, at the STOP sample point with rx_s==1 and parity failed, pulse parity_err, leave data unchanged, and return to IDLE.
REQ-019 SHALL, at the STOP sample point with rx_s==0, pulse frame_err only (never parity_err), leave data unchanged, and go to BREAK.
REQ-020 SHALL leave BREAK for IDLE only after rx_s==1 is seen; no start detection occurs in BREAK.
REQ-021 SHALL return to IDLE at mid-stop-bit, so a start bit following immediately is detected.
REQ-022 SHALL produce data_valid, parity_err and frame_err as mutually exclusive pulses, at most one pulse per frame.
REQ-023 SHALL have a latency of 1 clk from the STOP sample point to any output pulse.

Reset
REQ-024 SHALL, while rst_n==0 at a clk edge, set FSM=IDLE, counter=0, synchronizer flops=1, shift register=0, data=8'h00, and data_valid=parity_err=frame_err=busy=0.
REQ-025 SHALL abandon a frame in progress when reset is asserted mid-frame, with no pulse for it; after release, wait for rx_s high, then low, before starting a new frame.

Configuration
REQ-026 SHALL, with macro UART_RX_PARITY_EN defined, use the 8E1 frame described above.
REQ-027 SHALL, with UART_RX_PARITY_EN undefined, omit the PARITY state (DATA->STOP directly, 8N1 frame), tie parity_err to 0, and accept every frame whose stop bit is high.

Verification (CLKS_PER_BIT=16, UART_RX_PARITY_EN defined unless noted)
REQ-028 SHALL cover: frame 0xA5 with parity 0 and stop 1 -> data=8'hA5, one data_valid pulse, no error pulses.
REQ-029 SHALL cover: frame 0x01 with parity 0 (wrong) -> one parity_err pulse, data_valid stays 0, data holds its previous value.
REQ-030 SHALL cover: a 5-cycle low glitch on uart_rx -> no pulses, busy returns to 0 about 8 cycles after the glitch starts.
REQ-031 SHALL cover: frame 0x3C with stop bit 0 and the line held low for 40 cycles -> one frame_err pulse, FSM stays in BREAK until the line goes high, next valid frame 0x55 -> data=8'h55.
REQ-032 SHALL cover: back-to-back frames 0x12, 0x34 with no idle gap -> two data_valid pulses, in order.
REQ-033 SHALL cover: rst_n low during bit 4 of a frame, then a full frame 0x7E -> no pulse for the aborted frame, then data=8'h7E; repeated with UART_RX_PARITY_EN undefined and a 10-bit frame 0x7E -> data=8'h7E.
